cacheline_mem_arbiter: RTL and testbench
========================================

// Module: cacheline_mem_arbiter
// PURPOSE
//  Shares the single physical-memory line port between the I-cache (instruction fetch
//  path feeding the IF stage) and the D-cache (MEM stage).
//  - Grants one cache-line miss or writeback at a time.
//  - Latches the request at grant and drives the burst-level pmem interface.
//  - Returns the line and a one-cycle resp pulse to the granted cache only.
//  - Priority: D-cache first, with an anti-starvation override for the I-cache.
// PARAMETERS
//  LINE_WIDTH    256  bits per cache line / pmem data beat
//  ADDR_WIDTH    32   byte address width
//  STARVE_LIMIT  4    consecutive D grants while I waits before I is forced to win (>=1)
// PORTS
//  clk            in   1           clock, all state on posedge
//  reset          in   1           asynchronous, active-high
//  icache_read    in   1           I-cache line fill request, held until icache_resp
//  icache_addr    in   ADDR_WIDTH  I-cache line address
//  icache_rdata   out  LINE_WIDTH  returned line, valid when icache_resp=1
//  icache_resp    out  1           one-cycle completion pulse for I-cache
//  dcache_read    in   1           D-cache line fill request, held until dcache_resp
//  dcache_write   in   1           D-cache writeback request, held until dcache_resp
//  dcache_addr    in   ADDR_WIDTH  D-cache line address
//  dcache_wdata   in   LINE_WIDTH  writeback line
//  dcache_rdata   out  LINE_WIDTH  returned line, valid when dcache_resp=1
//  dcache_resp    out  1           one-cycle completion pulse for D-cache
//  pmem_read      out  1           memory read, held until pmem_resp
//  pmem_write     out  1           memory write, held until pmem_resp
//  pmem_address   out  ADDR_WIDTH  line-aligned address: low log2(LINE_WIDTH/8) bits = 0
//  pmem_wdata     out  LINE_WIDTH  write line
//  pmem_rdata     in   LINE_WIDTH  read line, valid with pmem_resp
//  pmem_resp      in   1           memory completion, one cycle
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; starve_cnt 0; latches cleared.
//  - FSM states: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
//  - IDLE:
//    - D pending (read|write) and (I idle or starve_cnt<STARVE_LIMIT) -> SERVE_D.
//      starve_cnt increments (saturating) only if icache_read is also high.
//    - Otherwise, if I pending -> SERVE_I and starve_cnt clears.
//    - Request addr, wdata and op are latched on the IDLE->SERVE transition.
//  - SERVE_x:
//    - pmem_read/pmem_write driven from the latched op; address and wdata come from
//      the latches, so requester changes after grant are ignored.
//    - On pmem_resp: capture pmem_rdata into x's rdata register, go to DONE_x;
//      pmem_read/write are 0 in the next cycle.
//  - DONE_x: x_resp=1 for exactly this cycle; rdata stays stable until the next
//    response to x. Requests are ignored in DONE (requester still holds req). Next
//    state is IDLE.
//  - Latency: grant to SERVE is 1 clk after request is seen in IDLE; resp is 1 clk
//    after pmem_resp; min request-to-resp = pmem latency + 2; back-to-back grants
//    have a 1-cycle IDLE gap.
//  - Writeback: dcache_write yields dcache_resp with dcache_rdata unchanged.
//  - Boundary conditions:
//    - pmem_resp in IDLE or DONE: ignored.
//    - dcache_read & dcache_write together: illegal; write wins; an SVA flags it.
//    - I and D requests arriving in the same cycle: priority rule above applies.
//    - Reset mid-SERVE: returns to IDLE immediately and drops pmem_read/write; a late
//      pmem_resp is ignored.
//    - starve_cnt saturates at STARVE_LIMIT.
// STRUCTURE
//  - Package rv32i_types gains: arbiter_state_t enum {IDLE,SERVE_I,SERVE_D,DONE_I,DONE_D}
//    and localparam LINE_OFFSET_BITS = $clog2(LINE_WIDTH/8).
//  - No sub-module. Latches and FSM are in-file; the state register uses an async-reset
//    always_ff. Existing register is sync-reset and is not reused.
// TESTING
//  1. I-only: icache_read, addr 0x0000_0064; pmem_resp 3 clk after pmem_read with
//     0xAB..AB -> pmem_address 0x0000_0060, icache_resp 1 clk later,
//     icache_rdata 0xAB..AB, dcache_resp stays 0.
//  2. Simultaneous I read 0x100 and D write 0x200 -> D served first (pmem_write,
//     pmem_wdata = dcache_wdata), then I served after dcache_resp plus the 1-cycle
//     IDLE gap.
//  3. Starvation: I held, D re-requests after every resp, STARVE_LIMIT=4 -> grant
//     order D,D,D,D,I, then counter clears.
//  4. Requester changes dcache_addr to 0x300 mid-SERVE_D -> pmem_address stays at the
//     latched 0x200 until pmem_resp.
//  5. Reset asserted while in SERVE_I with pmem_read=1 -> pmem_read 0 immediately
//     (async); pmem_resp pulse 2 clk after reset release -> no icache_resp.
//  6. Spurious pmem_resp in IDLE -> no resp pulse, state stays IDLE, rdata outputs
//     unchanged.

Source files
------------

// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cache-line memory arbiter: FSM state encoding and line geometry.
package rv32i_types;

   localparam int ARB_LINE_WIDTH   = 256;
   localparam int LINE_OFFSET_BITS = $clog2(ARB_LINE_WIDTH / 8);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SERVE_I = 3'd1,
      SERVE_D = 3'd2,
      DONE_I  = 3'd3,
      DONE_D  = 3'd4
   } arbiter_state_t;

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates the single pmem line port between I-cache and D-cache, one line
// transfer at a time, D-first with a starvation override for the I-cache.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer; picks the next requester
// SERVE_I | pmem read in flight for the I-cache
// SERVE_D | pmem read or writeback in flight for the D-cache
// DONE_I  | icache_resp pulse, line available on icache_rdata
// DONE_D  | dcache_resp pulse, line available on dcache_rdata
module cacheline_mem_arbiter
   import rv32i_types::*;
#(
   parameter int LINE_WIDTH   = 256,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_addr,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_addr,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   localparam int OFFS = $clog2(LINE_WIDTH / 8);
   localparam int CW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;
   localparam logic [CW-1:0]         LIMIT      = CW'(STARVE_LIMIT);

   arbiter_state_t state, state_nx;

   logic [CW-1:0]         starve_cnt;
   logic                  lat_write;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [LINE_WIDTH-1:0] lat_wdata;
   logic [LINE_WIDTH-1:0] irdata_q;
   logic [LINE_WIDTH-1:0] drdata_q;

   logic d_pend;
   logic grant_d;
   logic grant_i;

   // D wins unless the I-cache is waiting and has already lost STARVE_LIMIT times.
   assign d_pend  = dcache_read | dcache_write;
   assign grant_d = (state == IDLE) && d_pend && (!icache_read || (starve_cnt < LIMIT));
   assign grant_i = (state == IDLE) && !grant_d && icache_read;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (grant_d)      state_nx = SERVE_D;
            else if (grant_i) state_nx = SERVE_I;
         end
         SERVE_I: if (pmem_resp) state_nx = DONE_I;
         SERVE_D: if (pmem_resp) state_nx = DONE_D;
         DONE_I:  state_nx = IDLE;
         DONE_D:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state <= state_nx;
         if (grant_d && icache_read && (starve_cnt != LIMIT))
            starve_cnt <= starve_cnt + CW'(1);
         else if (grant_i)
            starve_cnt <= '0;
      end
   end

   // Request captured at grant so later requester changes cannot disturb the burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant_d) begin
         lat_write <= dcache_write;
         lat_addr  <= dcache_addr & ALIGN_MASK;
         lat_wdata <= dcache_wdata;
      end else if (grant_i) begin
         lat_write <= 1'b0;
         lat_addr  <= icache_addr & ALIGN_MASK;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irdata_q <= '0;
         drdata_q <= '0;
      end else if (pmem_resp) begin
         if (state == SERVE_I)
            irdata_q <= pmem_rdata;
         else if ((state == SERVE_D) && !lat_write)
            drdata_q <= pmem_rdata;
      end
   end

   assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !lat_write);
   assign pmem_write   = (state == SERVE_D) && lat_write;
   assign pmem_address = lat_addr;
   assign pmem_wdata   = lat_wdata;

   assign icache_resp  = (state == DONE_I);
   assign dcache_resp  = (state == DONE_D);
   assign icache_rdata = irdata_q;
   assign dcache_rdata = drdata_q;

   // Read and writeback together is a D-cache protocol error; the write is served.
   a_dcache_rw_exclusive : assert property (
      @(posedge clk) disable iff (reset) !(dcache_read && dcache_write)
   );

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Scoreboard bench for cacheline_mem_arbiter: directed requests, a pmem responder
// that logs grants, and a monitor that checks every resp pulse against queued values.
module tb_cacheline_mem_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          icache_read;
   logic [AW-1:0] icache_addr;
   logic [LW-1:0] icache_rdata;
   logic          icache_resp;
   logic          dcache_read;
   logic          dcache_write;
   logic [AW-1:0] dcache_addr;
   logic [LW-1:0] dcache_wdata;
   logic [LW-1:0] dcache_rdata;
   logic          dcache_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   cacheline_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .icache_read(icache_read), .icache_addr(icache_addr),
      .icache_rdata(icache_rdata), .icache_resp(icache_resp),
      .dcache_read(dcache_read), .dcache_write(dcache_write),
      .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic pmem_resp_q = 1'b0;
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      pmem_resp_q <= pmem_resp;
   end

   typedef struct {
      logic          w;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      int            cyc;
   } grant_t;

   grant_t        log_q[$];
   logic [LW-1:0] exp_i_q[$];
   logic [LW-1:0] exp_d_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            resp_en;
   int            mem_lat;
   int            d_resp_cyc;
   logic [LW-1:0] d_model;
   logic [LW-1:0] i_model;

   function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
      if (a == 32'h0000_0060) return {32{8'hAB}};
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   task automatic mem_responder();
      grant_t g;
      forever begin
         @(negedge clk);
         if (resp_en && (pmem_read || pmem_write)) begin
            g.w = pmem_write; g.addr = pmem_address; g.wdata = pmem_wdata; g.cyc = cyc;
            log_q.push_back(g);
            repeat (mem_lat - 1) @(negedge clk);
            pmem_rdata = mem_line(pmem_address);
            pmem_resp  = 1'b1;
            @(negedge clk);
            pmem_resp  = 1'b0;
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (icache_resp) begin
            if (exp_i_q.size() == 0) fail_now("unexpected_icache_resp");
            else begin
               chk("icache_rdata", icache_rdata, exp_i_q.pop_front());
               chk("icache_resp_latency", pmem_resp_q, 1'b1);
            end
         end
         if (dcache_resp) begin
            d_resp_cyc = cyc;
            if (exp_d_q.size() == 0) fail_now("unexpected_dcache_resp");
            else begin
               chk("dcache_rdata", dcache_rdata, exp_d_q.pop_front());
               chk("dcache_resp_latency", pmem_resp_q, 1'b1);
            end
         end
      end
   endtask

   task automatic wait_resp(input bit is_d);
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (is_d ? dcache_resp : icache_resp) return;
      end
      fail_now(is_d ? "dcache_resp_timeout" : "icache_resp_timeout");
   endtask

   task automatic wait_pmem();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (pmem_read || pmem_write) return;
      end
      fail_now("pmem_req_timeout");
   endtask

   task automatic pop_grant(input string name, input logic w, input logic [AW-1:0] addr,
                            output grant_t g);
      g.w = 1'bx; g.addr = 'x; g.wdata = 'x; g.cyc = -1;
      if (log_q.size() == 0) fail_now({name, "_missing"});
      else begin
         g = log_q.pop_front();
         chk({name, "_op"}, g.w, w);
         chk({name, "_addr"}, g.addr, addr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      grant_t        g;
      logic [AW-1:0] t3_addr[8];
      logic [LW-1:0] wb;
      reset = 1'b1;
      icache_read = 1'b0; icache_addr = '0;
      dcache_read = 1'b0; dcache_write = 1'b0; dcache_addr = '0; dcache_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      resp_en = 1'b1; mem_lat = 3; d_resp_cyc = 0;
      d_model = '0; i_model = '0;
      fork
         mem_responder();
         monitor();
      join_none
      repeat (2) @(negedge clk);

      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_write", pmem_write, 1'b0);
      chk("rst_pmem_address", pmem_address, '0);
      chk("rst_pmem_wdata", pmem_wdata, '0);
      chk("rst_icache_rdata", icache_rdata, '0);
      chk("rst_dcache_rdata", dcache_rdata, '0);
      chk("rst_resps", {icache_resp, dcache_resp}, 2'b00);
      reset = 1'b0;
      @(negedge clk);

      // I-only fill, unaligned address
      exp_i_q.push_back({32{8'hAB}});
      icache_addr = 32'h0000_0064; icache_read = 1'b1;
      wait_resp(1'b0);
      chk("t1_dcache_resp", dcache_resp, 1'b0);
      icache_read = 1'b0;
      i_model = {32{8'hAB}};
      pop_grant("t1_grant", 1'b0, 32'h0000_0060, g);

      // address change after grant is ignored
      mem_lat = 4;
      exp_d_q.push_back(mem_line(32'h200));
      dcache_addr = 32'h200; dcache_read = 1'b1;
      wait_pmem();
      @(negedge clk);
      dcache_addr = 32'h300;
      @(negedge clk);
      chk("t4_addr_held", pmem_address, 32'h200);
      chk("t4_read_held", pmem_read, 1'b1);
      wait_resp(1'b1);
      dcache_read = 1'b0;
      d_model = mem_line(32'h200);
      pop_grant("t4_grant", 1'b0, 32'h200, g);
      mem_lat = 3;

      // simultaneous I read and D writeback: D first, then I after one idle cycle
      wb = {8{32'hC0FF_EE00}};
      exp_d_q.push_back(d_model);
      exp_i_q.push_back(mem_line(32'h100));
      icache_addr = 32'h100; icache_read = 1'b1;
      dcache_addr = 32'h200; dcache_wdata = wb; dcache_write = 1'b1;
      fork
         begin wait_resp(1'b1); dcache_write = 1'b0; end
         begin wait_resp(1'b0); icache_read = 1'b0; end
      join
      i_model = mem_line(32'h100);
      pop_grant("t2_grant0", 1'b1, 32'h200, g);
      chk("t2_wdata", g.wdata, wb);
      pop_grant("t2_grant1", 1'b0, 32'h100, g);
      chk("t2_idle_gap", g.cyc - d_resp_cyc, 2);

      // starvation override: D,D,D,D,I then counter cleared so D wins again
      t3_addr = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h400, 32'h1100, 32'h1140, 32'h440};
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               logic [AW-1:0] a;
               a = 32'h1000 + AW'(k) * 32'h40;
               exp_d_q.push_back(mem_line(a));
               dcache_addr = a; dcache_read = 1'b1;
               wait_resp(1'b1);
            end
            dcache_read = 1'b0;
         end
         begin
            exp_i_q.push_back(mem_line(32'h400));
            icache_addr = 32'h400; icache_read = 1'b1;
            wait_resp(1'b0);
            exp_i_q.push_back(mem_line(32'h440));
            icache_addr = 32'h440;
            wait_resp(1'b0);
            icache_read = 1'b0;
         end
      join
      d_model = mem_line(32'h1140);
      i_model = mem_line(32'h440);
      for (int k = 0; k < 8; k++) begin
         pop_grant($sformatf("t3_grant%0d", k), 1'b0, t3_addr[k], g);
      end

      // spurious pmem_resp in IDLE
      resp_en = 1'b0;
      @(negedge clk);
      pmem_rdata = {8{32'hDEAD_BEEF}}; pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_icache_rdata", icache_rdata, i_model);
      chk("t6_dcache_rdata", dcache_rdata, d_model);
      chk("t6_pmem_idle", {pmem_read, pmem_write}, 2'b00);

      // reset while serving I, then a late pmem_resp
      icache_addr = 32'h500; icache_read = 1'b1;
      wait_pmem();
      chk("t5_read_before_reset", pmem_read, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_read_dropped", pmem_read, 1'b0);
      chk("t5_addr_cleared", pmem_address, '0);
      icache_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      pmem_rdata = {8{32'h1234_5678}}; pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_no_icache_resp", icache_resp, 1'b0);
      chk("t5_icache_rdata", icache_rdata, '0);
      chk("t5_pmem_idle", {pmem_read, pmem_write}, 2'b00);

      chk("exp_i_left", exp_i_q.size(), 0);
      chk("exp_d_left", exp_d_q.size(), 0);
      chk("grants_left", log_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
